// File: rtl/shift_ramp_generator_if.sv
`default_nettype none
// ============================================================================
//  Module      : shift_ramp_generator_if
//  Description : Control/status bundle between the synthesizer control FSM
//                (master) and the volume shift ramp generator (slave).
//                master drives: start, abort, shift_from, shift_to,
//                               step_size, step_interval
//                slave drives : shift_amount, busy, done, direction
//  Revision    : 1.0 - initial release
// ============================================================================
interface shift_ramp_generator_if #(
  parameter int SHIFT_W = 4,
  parameter int DIV_W   = 16
);

  // Request side
  logic               start;
  logic               abort;
  logic [SHIFT_W-1:0] shift_from;
  logic [SHIFT_W-1:0] shift_to;
  logic [SHIFT_W-1:0] step_size;
  logic [DIV_W-1:0]   step_interval;

  // Status side
  logic [SHIFT_W-1:0] shift_amount;
  logic               busy;
  logic               done;
  logic               direction;

  modport master (
    output start,
    output abort,
    output shift_from,
    output shift_to,
    output step_size,
    output step_interval,
    input  shift_amount,
    input  busy,
    input  done,
    input  direction
  );

  modport slave (
    input  start,
    input  abort,
    input  shift_from,
    input  shift_to,
    input  step_size,
    input  step_interval,
    output shift_amount,
    output busy,
    output done,
    output direction
  );

endinterface
`default_nettype wire

// File: rtl/shift_ramp_generator.sv
`default_nettype none
// ============================================================================
//  Module      : shift_ramp_generator
//  Description : Ramps a volume shift amount from a start value towards a
//                target in programmable steps at a programmable rate, and
//                clamps at the target so it never overshoots or wraps.
//                Up ramps (increasing shift) fade out, down ramps fade in.
//  Ports       : clock - system clock, rising edge
//                reset - synchronous, active-low
//                bus   - shift_ramp_generator_if.slave
//                        in : start, abort, shift_from, shift_to,
//                             step_size, step_interval
//                        out: shift_amount, busy, done, direction
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_ramp_generator #(
  parameter int SHIFT_W = 4,
  parameter int DIV_W   = 16
) (
  input  wire logic              clock,
  input  wire logic              reset,
  shift_ramp_generator_if.slave  bus
);

  localparam logic [SHIFT_W-1:0] c_step_one = SHIFT_W'(1);
  localparam logic [DIV_W-1:0]   c_div_one  = DIV_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;

  state_t             r_state;
  logic [SHIFT_W-1:0] r_target;
  logic [SHIFT_W-1:0] r_step;
  logic [DIV_W-1:0]   r_interval;
  logic [DIV_W-1:0]   r_divider;
  logic [SHIFT_W-1:0] r_shift;
  logic               r_busy;
  logic               r_done;
  logic               r_dir;

  // Zero step/interval would stall the ramp forever; both are promoted to 1.
  logic [SHIFT_W-1:0] w_step_in;
  logic [DIV_W-1:0]   w_interval_in;

  assign w_step_in     = (bus.step_size == '0)     ? c_step_one : bus.step_size;
  assign w_interval_in = (bus.step_interval == '0) ? c_div_one  : bus.step_interval;

  // One-bit-wider step arithmetic: the extra MSB catches carry out of the
  // top value on the way up and borrow below zero on the way down, so the
  // clamp against the target sees the true result instead of a wrapped one.
  logic [SHIFT_W:0]   w_target_ext;
  logic [SHIFT_W:0]   w_sum;
  logic [SHIFT_W:0]   w_diff;
  logic [SHIFT_W-1:0] w_up_next;
  logic [SHIFT_W-1:0] w_dn_next;
  logic [SHIFT_W-1:0] w_next_shift;
  logic               w_step_due;
  logic               w_at_target;

  assign w_target_ext = {1'b0, r_target};
  assign w_sum        = {1'b0, r_shift} + {1'b0, r_step};
  assign w_diff       = {1'b0, r_shift} - {1'b0, r_step};

  assign w_up_next = (w_sum >= w_target_ext) ? r_target : w_sum[SHIFT_W-1:0];

  // A set MSB means the subtraction went below zero, which is always past
  // the target regardless of how the low bits compare.
  assign w_dn_next = (w_diff[SHIFT_W] || (w_diff <= w_target_ext))
                     ? r_target : w_diff[SHIFT_W-1:0];

  assign w_next_shift = r_dir ? w_up_next : w_dn_next;
  assign w_step_due   = (r_divider == (r_interval - c_div_one));
  assign w_at_target  = (r_shift == r_target);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_target   <= '0;
      r_step     <= c_step_one;
      r_interval <= c_div_one;
      r_divider  <= '0;
      r_shift    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dir      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // done is a single-cycle pulse; clear it on the first idle edge.
          r_done <= 1'b0;
          if (bus.start && !bus.abort) begin
            r_target   <= bus.shift_to;
            r_step     <= w_step_in;
            r_interval <= w_interval_in;
            r_shift    <= bus.shift_from;
            r_dir      <= (bus.shift_to > bus.shift_from);
            r_divider  <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_RAMP;
          end
        end

        ST_RAMP: begin
          if (bus.abort) begin
            // Freeze wherever the ramp got to; no completion is reported.
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_at_target) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else if (w_step_due) begin
            r_divider <= '0;
            r_shift   <= w_next_shift;
          end else begin
            r_divider <= r_divider + c_div_one;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.shift_amount = r_shift;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.direction    = r_dir;

endmodule
`default_nettype wire

// File: doc/shift_ramp_generator.md
Name: shift_ramp_generator

Overview:
- Parametrised successor to the fixed up-counting volume shift stepper.
- Ramps a volume shift amount from a start value to a target in either direction (up = fade-out, down = fade-in).
- Step size and time between steps are programmable; the ramp clamps at the target, so it never overshoots or wraps.
- Sits between the synthesizer control FSM (start/abort/done) and the sample attenuator (right-shift by shift_amount).

Parameters:
- SHIFT_W, 4, width of the shift values: shift_from, shift_to, step_size, shift_amount.
- DIV_W, 16, width of the step-interval counter and of step_interval.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- abort  in  1  terminates an active ramp.
- shift_from  in  SHIFT_W  initial shift amount, latched on an accepted start.
- shift_to  in  SHIFT_W  target shift amount, latched on an accepted start.
- step_size  in  SHIFT_W  magnitude per step, latched on an accepted start; 0 is treated as 1.
- step_interval  in  DIV_W  clocks per step, latched on an accepted start; 0 is treated as 1.
- shift_amount  out  SHIFT_W  current shift value, registered.
- busy  out  1  high while in RAMP.
- done  out  1  one-cycle pulse when the target is reached.
- direction  out  1  1 = increasing (shift_to > shift_from), 0 otherwise; registered at start.

Behaviour:
- Reset (reset==0 at an edge) has priority over everything:
  - state=IDLE; shift_amount=0, busy=0, done=0, direction=0; divider=0.
  - Reset mid-ramp aborts with no done pulse.
- States: IDLE and RAMP.
- IDLE:
  - done is deasserted one cycle after it pulses; shift_amount holds its value.
  - On start=1 and abort=0 at an edge:
    - latch from/to/step/interval, applying the 0->1 substitution to step and interval;
    - shift_amount<=shift_from; direction<=(shift_to>shift_from); divider<=0; busy<=1; state<=RAMP.
  - start and abort together in IDLE: start is ignored.
- RAMP, evaluated in priority order at each edge:
  1. abort=1: state<=IDLE, busy<=0, done stays 0, shift_amount holds its current value.
  2. shift_amount==target: state<=IDLE, busy<=0, done<=1 for exactly one cycle, shift_amount holds (equals target).
  3. divider==interval-1: divider<=0, and shift_amount takes one step:
     - up: min(shift_amount+step, target);
     - down: max(shift_amount-step, target);
     - arithmetic is done in SHIFT_W+1 bits, so no wrap at 2^SHIFT_W-1 or at 0.
  4. otherwise divider<=divider+1.
- start is ignored while in RAMP; there is no retrigger.
- Latency:
  - The first step occurs interval edges after the accept edge.
  - done is asserted at edge N*interval+1 after the accept edge, where N=ceil(|to-from|/step).
  - For from==to, done is asserted at the edge immediately after the accept edge.
- Input changes after the accept edge have no effect until the next accepted start.
- done and busy are never high in the same cycle.

Test Plan:
- Up ramp: from=2, to=6, step=1, interval=3, start at edge 0 -> shift_amount=2 at edge 0, then 3/4/5/6 at edges 3/6/9/12; done=1 and busy=0 at edge 13 only; direction=1.
- Down ramp with clamp: from=12, to=3, step=4, interval=1 -> 8, 4, 3 at edges 1, 2, 3; done at edge 4; direction=0; never below 3.
- Saturation without wrap (SHIFT_W=4): from=13, to=15, step=4, interval=0 (treated as 1) -> 15 at edge 1, done at edge 2; value never wraps to 1.
- Abort and ignored start: from=0, to=10, step=1, interval=2; abort at edge 5 -> busy=0 at edge 5, shift_amount frozen at 2, no done pulse. A second start at edge 3 during the ramp has no effect on the sequence.
- Equal endpoints, then reset: from=to=7 -> shift_amount=7 and busy=1 at edge 0, done=1 at edge 1. Then restart from=0, to=15, step=1, interval=4; reset=0 at edge 6 -> shift_amount=0, busy=0, done=0, state IDLE at that edge.
